// File: rtl/bus_memory_pkg.sv
// Shared definitions for the CPU data-memory bus responder: I/O page addresses,
// STATUS bit positions and the address-region decoder.
package bus_memory_pkg;

  localparam logic [7:0] RAM_TOP     = 8'hEF;
  localparam logic [7:0] ADDR_TXDATA = 8'hF0;
  localparam logic [7:0] ADDR_STATUS = 8'hF1;
  localparam logic [7:0] ADDR_CYCLO  = 8'hF2;
  localparam logic [7:0] ADDR_CYCHI  = 8'hF3;
  localparam logic [7:0] ADDR_COUNT  = 8'hF4;

  localparam int unsigned OVF_BIT   = 3;
  localparam int unsigned FULL_BIT  = 2;
  localparam int unsigned EMPTY_BIT = 1;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_TXDATA,
    REG_STATUS,
    REG_CYCLO,
    REG_CYCHI,
    REG_COUNT,
    REG_NONE
  } region_e;

  // Unlisted I/O page addresses fall into REG_NONE: read 0, write ignored.
  function automatic region_e decode_addr(input logic [7:0] addr);
    region_e r;
    r = REG_NONE;
    if (addr <= RAM_TOP) begin
      r = REG_RAM;
    end else begin
      case (addr)
        ADDR_TXDATA: r = REG_TXDATA;
        ADDR_STATUS: r = REG_STATUS;
        ADDR_CYCLO:  r = REG_CYCLO;
        ADDR_CYCHI:  r = REG_CYCHI;
        ADDR_COUNT:  r = REG_COUNT;
        default:     r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_fifo.sv
// Transmit FIFO for the bus I/O page: push is dropped when full (pre-edge
// occupancy), head word reads 0 when empty, synchronous active-high reset.
module bus_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap naturally at PTR_W bits.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone define
  // what is valid, and a resettable array would block RAM inference.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/bus_memory.sv
// CPU data-memory bus responder: 240-word RAM plus an I/O page with a transmit
// FIFO and an optional free-running cycle counter (enabled by CYCLE_COUNTER_EN).
module bus_memory
  import bus_memory_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we,
  input  logic [7:0]        mem_addr,
  input  logic [DATA_W-1:0] mem_in,
  output logic [DATA_W-1:0] mem_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int RAM_WORDS  = int'(RAM_TOP) + 1;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bus_memory: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (DATA_W != 16) begin : g_bad_width
    $error("bus_memory: DATA_W is fixed at 16");
  end

  region_e             region;
  logic                wr_en;
  logic                tx_push;
  logic                tx_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [DATA_W-1:0]   fifo_head;
  logic                ovf;
  logic [DATA_W-1:0]   status_word;
  logic [DATA_W-1:0]   ram [RAM_WORDS];

  assign region = decode_addr(mem_addr);
  // A write strobe during reset is discarded for every region, RAM included.
  assign wr_en   = mem_we && !rst;
  assign tx_push = wr_en && (region == REG_TXDATA);
  assign tx_pop  = out_valid && out_ready;

  bus_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (mem_in),
    .pop       (tx_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head;

  // Sticky overflow: set by a dropped push, cleared only by software or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (tx_push && fifo_full) begin
      ovf <= 1'b1;
    end else if (wr_en && (region == REG_STATUS) && mem_in[OVF_BIT]) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && (region == REG_RAM)) ram[mem_addr] <= mem_in;
  end

`ifdef CYCLE_COUNTER_EN
  logic [2*DATA_W-1:0] cycle_cnt;

  // A write to either half loads 0; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst || (wr_en && (region == REG_CYCLO || region == REG_CYCHI))) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + (2*DATA_W)'(1);
    end
  end
`endif

  always_comb begin
    status_word            = '0;
    status_word[OVF_BIT]   = ovf;
    status_word[FULL_BIT]  = fifo_full;
    status_word[EMPTY_BIT] = fifo_empty;
  end

  // NOTE: mem_out gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_out = '0;
    case (region)
      REG_RAM:    mem_out = ram[mem_addr];
      REG_STATUS: mem_out = status_word;
      REG_COUNT:  mem_out = DATA_W'(fifo_count);
`ifdef CYCLE_COUNTER_EN
      REG_CYCLO:  mem_out = cycle_cnt[DATA_W-1:0];
      REG_CYCHI:  mem_out = cycle_cnt[2*DATA_W-1:DATA_W];
`endif
      default:    mem_out = '0;
    endcase
  end

endmodule

// File: tb/tb_bus_memory.sv
// Scoreboard bench for bus_memory: stimulus queues expected read/transmit words,
// negedge monitors pop and compare them against the DUT outputs.
module tb_bus_memory;
  import bus_memory_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_in;
  logic [15:0] mem_out;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] rd_exp_q [$];
  string       rd_name_q [$];
  logic [15:0] tx_exp_q [$];
  logic        chk_rd = 1'b0;

  bus_memory #(.FIFO_DEPTH(4), .DATA_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_in    (mem_in),
    .mem_out   (mem_out),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Read-port monitor: one expected word per flagged bus cycle.
  always @(negedge clk) begin
    if (chk_rd && rd_exp_q.size() != 0) begin
      logic [15:0] e;
      string       n;
      e = rd_exp_q.pop_front();
      n = rd_name_q.pop_front();
      check(n, mem_out, e);
    end
  end

  // Transmit monitor: every accepted handshake must match the next queued word.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (tx_exp_q.size() == 0) check("tx_unexpected_valid", {15'b0, out_valid}, 16'h0000);
      else                      check("tx_data", out_data, tx_exp_q.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [15:0] data);
    mem_we   = 1'b1;
    mem_addr = addr;
    mem_in   = data;
    @(posedge clk);
    #1;
    mem_we   = 1'b0;
  endtask

  // One bus cycle with an expected read value, optionally writing in the same cycle.
  task automatic access(input logic [7:0] addr, input logic we, input logic [15:0] wdata,
                        input logic [15:0] exp, input string name);
    mem_we   = we;
    mem_addr = addr;
    mem_in   = wdata;
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    chk_rd   = 1'b1;
    @(posedge clk);
    #1;
    chk_rd   = 1'b0;
    mem_we   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [15:0] exp, input string name);
    access(addr, 1'b0, 16'h0000, exp, name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] words [5];
    words[0] = 16'h0011; words[1] = 16'h0022; words[2] = 16'h0033;
    words[3] = 16'h0044; words[4] = 16'h0055;

    rst = 1'b1; mem_we = 1'b0; mem_addr = 8'h00; mem_in = 16'h0000; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_out_valid", {15'b0, out_valid}, 16'h0000);
    rd(ADDR_STATUS, 16'h0002, "rst_status");
    rd(ADDR_COUNT,  16'h0000, "rst_count");

    // RAM: boundary words and read-before-write in the same cycle.
    wr(8'h05, 16'h1234);
    wr(RAM_TOP, 16'hBEEF);
    rd(8'h05, 16'h1234, "ram_05");
    rd(RAM_TOP, 16'hBEEF, "ram_ef");
    access(8'h05, 1'b1, 16'h5678, 16'h1234, "ram_same_cycle_old");
    rd(8'h05, 16'h5678, "ram_after_write");

    // Overfill with consumer stalled, then drain.
    for (int i = 0; i < 5; i++) begin
      wr(ADDR_TXDATA, words[i]);
      if (i < 4) tx_exp_q.push_back(words[i]);
    end
    rd(ADDR_COUNT,  16'h0004, "count_full");
    rd(ADDR_STATUS, 16'h000C, "status_ovf_full");
    out_ready = 1'b1;
    idle(4);
    check("drained_out_valid", {15'b0, out_valid}, 16'h0000);
    check("drained_out_data", out_data, 16'h0000);
    rd(ADDR_STATUS, 16'h000A, "status_ovf_empty");
    rd(ADDR_TXDATA, 16'h0000, "txdata_reads_0");
    out_ready = 1'b0;

    wr(ADDR_STATUS, 16'h0008);
    rd(ADDR_STATUS, 16'h0002, "status_ovf_cleared");

    // Push while full with a simultaneous pop: push still dropped.
    for (int i = 0; i < 4; i++) begin
      wr(ADDR_TXDATA, 16'hA1 + 16'(i));
      tx_exp_q.push_back(16'hA1 + 16'(i));
    end
    rd(ADDR_STATUS, 16'h0004, "status_full_no_ovf");
    out_ready = 1'b1;
    wr(ADDR_TXDATA, 16'h0099);
    out_ready = 1'b0;
    rd(ADDR_COUNT,  16'h0003, "count_after_drop");
    rd(ADDR_STATUS, 16'h0008, "status_ovf_after_drop");
    wr(ADDR_STATUS, 16'h0008);
    rd(ADDR_STATUS, 16'h0000, "status_ovf_clear2");
    out_ready = 1'b1;
    idle(3);
    out_ready = 1'b0;
    rd(ADDR_STATUS, 16'h0002, "status_empty_again");

    // Cycle counter.
    wr(ADDR_CYCLO, 16'h1234);
`ifdef CYCLE_COUNTER_EN
    rd(ADDR_CYCLO, 16'h0000, "cyclo_after_load");
    rd(ADDR_CYCLO, 16'h0001, "cyclo_plus1");
    idle(65533);
    rd(ADDR_CYCHI, 16'h0000, "cychi_before_carry");
    rd(ADDR_CYCLO, 16'h0000, "cyclo_wrap");
    rd(ADDR_CYCHI, 16'h0001, "cychi_carry");
    wr(ADDR_CYCHI, 16'hFFFF);
    rd(ADDR_CYCHI, 16'h0000, "cychi_after_load");
    rd(ADDR_CYCLO, 16'h0001, "cyclo_after_hi_load");
`else
    rd(ADDR_CYCLO, 16'h0000, "cyclo_absent");
    rd(ADDR_CYCHI, 16'h0000, "cychi_absent");
    idle(5);
    rd(ADDR_CYCLO, 16'h0000, "cyclo_absent_later");
`endif

    // Unused addresses and read-only COUNT.
    rd(8'hF7, 16'h0000, "unused_f7");
    rd(8'hFF, 16'h0000, "unused_ff");
    wr(ADDR_TXDATA, 16'h00C1);
    wr(ADDR_TXDATA, 16'h00C2);
    wr(ADDR_COUNT, 16'hFFFF);
    rd(ADDR_COUNT, 16'h0002, "count_write_ignored");

    // Reset mid-stream with write strobes to TXDATA and RAM.
    for (int i = 0; i < 3; i++) wr(ADDR_TXDATA, 16'h00C3 + 16'(i));
    rd(ADDR_STATUS, 16'h000C, "status_before_reset");
    rst = 1'b1; mem_we = 1'b1; mem_addr = ADDR_TXDATA; mem_in = 16'h0077;
    @(posedge clk); #1;
    mem_addr = 8'h05; mem_in = 16'hDEAD;
    @(posedge clk); #1;
    rst = 1'b0; mem_we = 1'b0;
    check("reset_out_valid", {15'b0, out_valid}, 16'h0000);
    rd(ADDR_CYCLO,  16'h0000, "reset_counter");
    rd(ADDR_COUNT,  16'h0000, "reset_count");
    rd(ADDR_STATUS, 16'h0002, "reset_status");
    rd(8'h05,       16'h5678, "reset_ram_write_ignored");

    wr(ADDR_TXDATA, 16'h00E1);
    tx_exp_q.push_back(16'h00E1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("post_reset_drained", {15'b0, out_valid}, 16'h0000);

    idle(2);
    check("tx_queue_drained", 16'(tx_exp_q.size()), 16'h0000);
    check("rd_queue_drained", 16'(rd_exp_q.size()), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
